// File: rtl/uart_rx_fifo.sv
// UART receiver with false-start filtering and error detection,
// feeding a first-word-fall-through receive FIFO.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iRx,
  input  logic                 iRxReady,
  input  logic                 iClrErr,
  output logic [DATA_BITS-1:0] oRxData,
  output logic                 oRxValid,
  output logic                 oParityErr,
  output logic                 oFrameErr,
  output logic                 oOverrun,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] oFifoCount
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t MID_BIT  = cnt_t'(CLKS_PER_BIT / 2 - 1);
  localparam cnt_t FULL_BIT = cnt_t'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic [OCC_W-1:0] DEPTH = OCC_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    Idle, Start, Data, ParityBit, Stop, WaitHigh
  } state_t;

  state_t state, stateNext;
  logic sync1, rxS;
  cnt_t clkCnt;
  logic [3:0] bitIdx;
  logic [DATA_BITS-1:0] shiftReg;
  logic parTag, stopErr, pushReg, frameErr;
  logic tick, lastStop, stopBad;

  assign tick     = (clkCnt == FULL_BIT);
  assign lastStop = (bitIdx == LAST_STOP);
  assign stopBad  = stopErr | ~rxS;

  always_comb begin
    stateNext = state;
    unique case (state)
      Idle:
        if (!rxS) stateNext = Start;
      Start:
        if (clkCnt == MID_BIT)
          stateNext = rxS ? Idle : Data;
      Data:
        if (tick && bitIdx == LAST_DATA)
          stateNext = (PARITY != 0) ? ParityBit : Stop;
      ParityBit:
        if (tick) stateNext = Stop;
      Stop:
        if (tick && lastStop)
          stateNext = rxS ? Idle : WaitHigh;
      WaitHigh:
        if (rxS) stateNext = Idle;
      default:
        stateNext = Idle;
    endcase
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state    <= Idle;
      sync1    <= 1'b1;
      rxS      <= 1'b1;
      clkCnt   <= '0;
      bitIdx   <= '0;
      shiftReg <= '0;
      parTag   <= 1'b0;
      stopErr  <= 1'b0;
      pushReg  <= 1'b0;
      frameErr <= 1'b0;
    end else begin
      sync1    <= iRx;
      rxS      <= sync1;
      state    <= stateNext;
      pushReg  <= 1'b0;
      frameErr <= 1'b0;
      if (state != stateNext || tick)
        clkCnt <= '0;
      else
        clkCnt <= clkCnt + 1'b1;
      if (state == Start) begin
        bitIdx  <= '0;
        parTag  <= 1'b0;
        stopErr <= 1'b0;
      end
      if (tick) begin
        unique case (state)
          Data: begin
            shiftReg <= {rxS, shiftReg[DATA_BITS-1:1]};
            bitIdx <= (bitIdx == LAST_DATA) ? 4'd0
                                            : bitIdx + 4'd1;
          end
          ParityBit:
            parTag <= (PARITY == 1) ? ~(^shiftReg ^ rxS)
                                    : (^shiftReg ^ rxS);
          Stop: begin
            if (lastStop) begin
              frameErr <= stopBad;
              pushReg  <= ~stopBad;
              bitIdx   <= '0;
            end else begin
              stopErr <= stopBad;
              bitIdx  <= bitIdx + 4'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Each entry holds {parity tag, data}.
  logic [DATA_BITS:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [OCC_W-1:0] count;
  logic overrun, pop, full, wrEn, lost;

  assign oRxValid = (count != '0);
  assign pop  = oRxValid & iRxReady;
  assign full = (count == DEPTH);
  assign wrEn = pushReg & (~full | pop);
  assign lost = pushReg & full & ~pop;

  always_ff @(posedge iClk) begin
    if (wrEn) mem[wrPtr] <= {parTag, shiftReg};
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      count   <= '0;
      overrun <= 1'b0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (wrEn && !pop)
        count <= count + 1'b1;
      else if (pop && !wrEn)
        count <= count - 1'b1;
      if (lost)
        overrun <= 1'b1;
      else if (iClrErr)
        overrun <= 1'b0;
    end
  end

  // Gate the head so outputs read zero while empty.
  assign {oParityErr, oRxData} =
    oRxValid ? mem[rdPtr] : '0;
  assign oFrameErr  = frameErr;
  assign oOverrun   = overrun;
  assign oFifoCount = count;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Scoreboard bench for uart_rx_fifo: 8N1, 8E1 and 8N2 instances
// driven by a serial line model and checked by a pop monitor.
module tb_uart_rx_fifo;

  localparam int CPB = 10;
  localparam int NI = 3;

  typedef struct {
    logic [7:0] d;
    logic p;
  } exp_t;

  logic clk = 0;
  logic rst = 1;
  logic rx [NI];
  logic ready [NI];
  logic clr [NI];
  logic [7:0] rxData [NI];
  logic valid [NI];
  logic parErr [NI];
  logic frameErr [NI];
  logic ovr [NI];
  logic [4:0] cnt [NI];

  exp_t expQ [NI][$];
  bit expOvr [NI];
  int feCnt [NI];
  int checks = 0;
  int errors = 0;
  bit doneA, doneB;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dutN (
    .iClk(clk), .iRst(rst), .iRx(rx[0]),
    .iRxReady(ready[0]), .iClrErr(clr[0]),
    .oRxData(rxData[0]), .oRxValid(valid[0]),
    .oParityErr(parErr[0]), .oFrameErr(frameErr[0]),
    .oOverrun(ovr[0]), .oFifoCount(cnt[0])
  );

  uart_rx_fifo #(
    .CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16)
  ) dutE (
    .iClk(clk), .iRst(rst), .iRx(rx[1]),
    .iRxReady(ready[1]), .iClrErr(clr[1]),
    .oRxData(rxData[1]), .oRxValid(valid[1]),
    .oParityErr(parErr[1]), .oFrameErr(frameErr[1]),
    .oOverrun(ovr[1]), .oFifoCount(cnt[1])
  );

  uart_rx_fifo #(
    .CLK_FREQ(100), .BAUD_RATE(10), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(16)
  ) dutS (
    .iClk(clk), .iRst(rst), .iRx(rx[2]),
    .iRxReady(ready[2]), .iClrErr(clr[2]),
    .oRxData(rxData[2]), .oRxValid(valid[2]),
    .oParityErr(parErr[2]), .oFrameErr(frameErr[2]),
    .oOverrun(ovr[2]), .oFifoCount(cnt[2])
  );

  task automatic check(input string name,
                       input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head word must match the oldest expectation.
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      feCnt[k] += int'(frameErr[k]);
      if (!rst && valid[k] && ready[k]) begin
        exp_t e;
        checks++;
        if (expQ[k].size() == 0) begin
          errors++;
          $display("FAIL pop%0d: unexpected word %h", k, rxData[k]);
        end else begin
          e = expQ[k].pop_front();
          if (rxData[k] !== e.d || parErr[k] !== e.p) begin
            errors++;
            $display("FAIL pop%0d: got %h/%b want %h/%b",
                     k, rxData[k], parErr[k], e.d, e.p);
          end
        end
      end
    end
  end

  // Reference: a good frame yields its data word; the tag is set when the
  // parity bit on the line differs from the one the mode calls for.
  task automatic expectWord(input int k, input logic [7:0] d,
                            input bit tag);
    exp_t e;
    e.d = d;
    e.p = tag;
    if (expQ[k].size() < 16) expQ[k].push_back(e);
    else expOvr[k] = 1'b1;
  endtask

  task automatic sendBits(input int k, input logic [15:0] bits,
                          input int n);
    for (int i = 0; i < n; i++) begin
      rx[k] = bits[i];
      repeat (CPB) step();
    end
    rx[k] = 1'b1;
  endtask

  task automatic sendByte(input int k, input logic [7:0] d,
                          input int pm, input bit badPar,
                          input bit badStop, input int nStop);
    logic [15:0] bits;
    int n;
    logic p;
    bits = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    n = 9;
    if (pm != 0) begin
      p = (pm == 2) ? ^d : ~^d;
      bits[n] = p ^ badPar;
      n++;
    end
    for (int s = 0; s < nStop; s++) begin
      bits[n] = !(badStop && s == 0);
      n++;
    end
    sendBits(k, bits, n);
  endtask

  task automatic measure(input int k, output int lat);
    int m;
    m = 0;
    do begin
      step();
      m++;
    end while (!valid[k] && m < 300);
    lat = m - 1;
  endtask

  task automatic drain(input int k);
    int m;
    ready[k] = 1'b1;
    m = 0;
    while (cnt[k] != 0 && m < 200) begin
      step();
      m++;
    end
    step();
  endtask

  initial begin
    int lat, fe0;
    logic [15:0] partial;
    for (int k = 0; k < NI; k++) begin
      rx[k] = 1'b1;
      ready[k] = 1'b0;
      clr[k] = 1'b0;
      expOvr[k] = 1'b0;
      feCnt[k] = 0;
    end
    repeat (3) step();
    for (int k = 0; k < NI; k++) begin
      check("rst_valid", int'(valid[k]), 0);
      check("rst_flags", int'({ovr[k], frameErr[k], parErr[k]}), 0);
      check("rst_count", int'(cnt[k]), 0);
    end
    check("rst_data", int'(rxData[0]), 0);
    rst = 1'b0;
    repeat (5) step();

    // 8N1 latency and single pop
    expectWord(0, 8'h48, 1'b0);
    fork
      sendByte(0, 8'h48, 0, 0, 0, 1);
      measure(0, lat);
    join
    check("lat_8n1", lat, CPB * 10 - CPB / 2 + 3);
    check("s1_data", int'(rxData[0]), 'h48);
    check("s1_par", int'(parErr[0]), 0);
    check("s1_count", int'(cnt[0]), 1);
    ready[0] = 1'b1;
    step();
    ready[0] = 1'b0;
    step();
    check("s1_count_pop", int'(cnt[0]), 0);
    check("s1_valid_pop", int'(valid[0]), 0);

    // 8N2 latency
    expectWord(2, 8'h48, 1'b0);
    fork
      sendByte(2, 8'h48, 0, 0, 0, 2);
      measure(2, lat);
    join
    check("lat_8n2", lat, CPB * 11 - CPB / 2 + 3);
    check("s6_count", int'(cnt[2]), 1);
    drain(2);
    ready[2] = 1'b0;

    // even parity: bad then good
    ready[1] = 1'b1;
    expectWord(1, 8'h48, 1'b1);
    sendByte(1, 8'h48, 2, 1, 0, 1);
    expectWord(1, 8'h41, 1'b0);
    sendByte(1, 8'h41, 2, 0, 0, 1);
    repeat (10) step();
    check("s2_empty", expQ[1].size(), 0);

    // framing error then recovery
    ready[0] = 1'b1;
    fe0 = feCnt[0];
    sendByte(0, 8'h55, 0, 0, 1, 1);
    repeat (20) step();
    check("s3_fe", feCnt[0] - fe0, 1);
    check("s3_count", int'(cnt[0]), 0);
    expectWord(0, 8'h33, 1'b0);
    sendByte(0, 8'h33, 0, 0, 0, 1);
    repeat (10) step();
    check("s3_next", expQ[0].size(), 0);

    // glitch and break
    fe0 = feCnt[0];
    rx[0] = 1'b0;
    repeat (3) step();
    rx[0] = 1'b1;
    repeat (30) step();
    check("s4_glitch_fe", feCnt[0] - fe0, 0);
    check("s4_glitch_cnt", int'(cnt[0]), 0);
    rx[0] = 1'b0;
    repeat (300) step();
    rx[0] = 1'b1;
    repeat (50) step();
    check("s4_break_fe", feCnt[0] - fe0, 1);
    check("s4_break_cnt", int'(cnt[0]), 0);

    // overrun
    ready[0] = 1'b0;
    for (int i = 0; i < 17; i++) begin
      expectWord(0, 8'(i), 1'b0);
      sendByte(0, 8'(i), 0, 0, 0, 1);
    end
    repeat (5) step();
    check("s5_count", int'(cnt[0]), 16);
    check("s5_ovr", int'(ovr[0]), int'(expOvr[0]));
    drain(0);
    check("s5_drained", expQ[0].size(), 0);
    check("s5_sticky", int'(ovr[0]), 1);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    expOvr[0] = 1'b0;
    step();
    check("s5_clr", int'(ovr[0]), int'(expOvr[0]));

    // reset mid data bit
    partial = 16'hFFFE;
    sendBits(0, partial, 3);
    rx[0] = 1'b0;
    repeat (5) step();
    rst = 1'b1;
    repeat (2) step();
    rx[0] = 1'b1;
    rst = 1'b0;
    step();
    check("s6_rst_out", int'({valid[0], ovr[0], frameErr[0]}), 0);
    check("s6_rst_cnt", int'(cnt[0]), 0);
    repeat (20) step();
    check("s6_rst_idle", int'(cnt[0]), 0);
    expectWord(0, 8'hA5, 1'b0);
    sendByte(0, 8'hA5, 0, 0, 0, 1);
    repeat (10) step();
    check("s6_next", expQ[0].size(), 0);

    // randomized traffic with random back-pressure
    doneA = 0;
    doneB = 0;
    fork
      begin
        for (int i = 0; i < 20; i++) begin
          logic [7:0] d;
          d = 8'($urandom);
          expectWord(0, d, 1'b0);
          sendByte(0, d, 0, 0, 0, 1);
          repeat ($urandom_range(0, 5)) step();
        end
        doneA = 1;
      end
      begin
        for (int i = 0; i < 12; i++) begin
          logic [7:0] d;
          bit bad;
          d = 8'($urandom);
          bad = bit'($urandom_range(0, 1));
          expectWord(1, d, bad);
          sendByte(1, d, 2, bad, 0, 1);
          repeat ($urandom_range(0, 5)) step();
        end
        doneB = 1;
      end
      begin
        while (!(doneA && doneB)) begin
          ready[0] = 1'($urandom_range(0, 1));
          ready[1] = 1'($urandom_range(0, 1));
          step();
        end
      end
    join
    drain(0);
    drain(1);
    repeat (10) step();
    for (int k = 0; k < NI; k++)
      check("final_empty", expQ[k].size() + int'(cnt[k]), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
